// File: rtl/square_renderer.sv
// Erases each square's previous footprint, then redraws it at its new position, one pixel per cycle.
// Define SQ_SKIP_STATIC_EN to skip squares whose position and colour are unchanged since the last frame.
module square_renderer #(
  parameter int         N_SQUARES = 4,
  parameter int         SIZE      = 4,
  parameter logic [2:0] BG_COLOUR = 3'b000,
  parameter int         SCREEN_W  = 160,
  parameter int         SCREEN_H  = 120
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   draw_squares,
  input  logic [N_SQUARES*8-1:0] sq_x,
  input  logic [N_SQUARES*7-1:0] sq_y,
  input  logic [N_SQUARES*3-1:0] sq_colour,
  output logic [7:0]             x_out,
  output logic [6:0]             y_out,
  output logic [2:0]             colour_out,
  output logic                   writeEn,
  output logic                   finish_drawing_squares
);

  localparam int IW = (N_SQUARES > 1) ? $clog2(N_SQUARES) : 1;
  localparam int LW = $clog2(SIZE);
  localparam int PW = 2 * LW;
  localparam logic [PW-1:0] P_LAST = PW'(SIZE * SIZE - 1);
  localparam logic [IW-1:0] I_LAST = IW'(N_SQUARES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, ERASE, DRAW, DONE} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        i_q, i_d;
  logic [PW-1:0]        p_q, p_d;
  logic                 armed_q, armed_d;
  logic [7:0]           new_x_q, new_x_d;
  logic [6:0]           new_y_q, new_y_d;
  logic [2:0]           new_colour_q, new_colour_d;
  logic [N_SQUARES-1:0] old_valid_q, old_valid_d;
  logic [7:0]           old_x_q [N_SQUARES];
  logic [7:0]           old_x_d [N_SQUARES];
  logic [6:0]           old_y_q [N_SQUARES];
  logic [6:0]           old_y_d [N_SQUARES];
`ifdef SQ_SKIP_STATIC_EN
  logic [2:0]           old_c_q [N_SQUARES];
  logic [2:0]           old_c_d [N_SQUARES];
`endif

  logic       static_sq;
  logic       last_sq;
  logic       active;
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [8:0] px;
  logic [7:0] py;

  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    p_d          = p_q;
    armed_d      = armed_q;
    new_x_d      = new_x_q;
    new_y_d      = new_y_q;
    new_colour_d = new_colour_q;
    old_valid_d  = old_valid_q;
    old_x_d      = old_x_q;
    old_y_d      = old_y_q;
    last_sq      = (i_q == I_LAST);
`ifdef SQ_SKIP_STATIC_EN
    old_c_d      = old_c_q;
    static_sq    = old_valid_q[i_q]
                && (sq_x[i_q*8 +: 8] == old_x_q[i_q])
                && (sq_y[i_q*7 +: 7] == old_y_q[i_q])
                && (sq_colour[i_q*3 +: 3] == old_c_q[i_q]);
`else
    static_sq    = 1'b0;
`endif

    // Losing the enable mid-frame abandons the frame without committing the current square.
    if (!draw_squares && (state_q == LOAD || state_q == ERASE || state_q == DRAW)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (draw_squares && armed_q) begin
            state_d = LOAD;
            i_d     = '0;
          end
        end
        LOAD: begin
          new_x_d      = sq_x[i_q*8 +: 8];
          new_y_d      = sq_y[i_q*7 +: 7];
          new_colour_d = sq_colour[i_q*3 +: 3];
          p_d          = '0;
          if (static_sq) begin
            state_d = last_sq ? DONE : LOAD;
            i_d     = last_sq ? i_q : i_q + IW'(1);
          end else begin
            state_d = old_valid_q[i_q] ? ERASE : DRAW;
          end
        end
        ERASE: begin
          if (p_q == P_LAST) begin
            p_d     = '0;
            state_d = DRAW;
          end else begin
            p_d = p_q + PW'(1);
          end
        end
        DRAW: begin
          if (p_q == P_LAST) begin
            old_x_d[i_q]     = new_x_q;
            old_y_d[i_q]     = new_y_q;
            old_valid_d[i_q] = 1'b1;
`ifdef SQ_SKIP_STATIC_EN
            old_c_d[i_q]     = new_colour_q;
`endif
            state_d = last_sq ? DONE : LOAD;
            i_d     = last_sq ? i_q : i_q + IW'(1);
          end else begin
            p_d = p_q + PW'(1);
          end
        end
        DONE: begin
          armed_d = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // A low enable always re-arms, so a held-high enable yields only one frame.
    if (!draw_squares) armed_d = 1'b1;
  end

  always_comb begin
    active = (state_q == ERASE) || (state_q == DRAW);
    base_x = (state_q == ERASE) ? old_x_q[i_q] : new_x_q;
    base_y = (state_q == ERASE) ? old_y_q[i_q] : new_y_q;
    px     = {1'b0, base_x} + 9'(p_q[LW-1:0]);
    py     = {1'b0, base_y} + 8'(p_q[PW-1:LW]);
    x_out      = active ? px[7:0] : 8'd0;
    y_out      = active ? py[6:0] : 7'd0;
    colour_out = (state_q == ERASE) ? BG_COLOUR : ((state_q == DRAW) ? new_colour_q : 3'd0);
    writeEn    = active && (px < 9'(SCREEN_W)) && (py < 8'(SCREEN_H));
    finish_drawing_squares = (state_q == DONE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      i_q          <= '0;
      p_q          <= '0;
      armed_q      <= 1'b0;
      new_x_q      <= '0;
      new_y_q      <= '0;
      new_colour_q <= '0;
      old_valid_q  <= '0;
      for (int k = 0; k < N_SQUARES; k++) begin
        old_x_q[k] <= '0;
        old_y_q[k] <= '0;
`ifdef SQ_SKIP_STATIC_EN
        old_c_q[k] <= '0;
`endif
      end
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      p_q          <= p_d;
      armed_q      <= armed_d;
      new_x_q      <= new_x_d;
      new_y_q      <= new_y_d;
      new_colour_q <= new_colour_d;
      old_valid_q  <= old_valid_d;
      old_x_q      <= old_x_d;
      old_y_q      <= old_y_d;
`ifdef SQ_SKIP_STATIC_EN
      old_c_q      <= old_c_d;
`endif
    end
  end

endmodule

// File: tb/tb_square_renderer.sv
// Bench for square_renderer: frame-level reference model of erase/draw order, clipping, latency and abort.
module tb_square_renderer;
  localparam int N = 4;
  localparam int S = 4;
`ifdef SQ_SKIP_STATIC_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           reset;
  logic           draw_squares;
  logic [N*8-1:0] sq_x;
  logic [N*7-1:0] sq_y;
  logic [N*3-1:0] sq_colour;
  logic [7:0]     x_out;
  logic [6:0]     y_out;
  logic [2:0]     colour_out;
  logic           writeEn;
  logic           finish_drawing_squares;

  int errors = 0;
  int checks = 0;

  square_renderer dut (
    .clock(clock), .reset(reset), .draw_squares(draw_squares),
    .sq_x(sq_x), .sq_y(sq_y), .sq_colour(sq_colour),
    .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
    .writeEn(writeEn), .finish_drawing_squares(finish_drawing_squares)
  );

  always #5 clock = ~clock;

  // Requested positions for the next frame, and the model's view of what is on screen.
  int   nx[N], ny[N], nc[N];
  int   ox[N], oy[N], oc[N];
  bit   ov[N];
  logic [17:0] exp_q[$];
  logic [17:0] got_q[$];
  int   exp_len, draw2_start, fin_cnt;

  always @(negedge clock) begin
    if (writeEn) got_q.push_back({x_out, y_out, colour_out});
    if (finish_drawing_squares) fin_cnt++;
  end

  task automatic apply_inputs();
    for (int k = 0; k < N; k++) begin
      sq_x[8*k +: 8]      = 8'(nx[k]);
      sq_y[7*k +: 7]      = 7'(ny[k]);
      sq_colour[3*k +: 3] = 3'(nc[k]);
    end
  endtask

  task automatic model_square(input int bx, input int by, input int c);
    for (int dy = 0; dy < S; dy++)
      for (int dx = 0; dx < S; dx++)
        if (bx + dx < 160 && by + dy < 120)
          exp_q.push_back({8'(bx + dx), 7'(by + dy), 3'(c)});
  endtask

  task automatic model_frame();
    int cyc;
    exp_q.delete();
    cyc = 0;
    draw2_start = -1;
    for (int k = 0; k < N; k++) begin
      cyc++;
      if (SKIP && ov[k] && ox[k] == nx[k] && oy[k] == ny[k] && oc[k] == nc[k]) continue;
      if (ov[k]) begin
        model_square(ox[k], oy[k], 0);
        cyc += S * S;
      end
      if (k == 2) draw2_start = cyc + 1;
      model_square(nx[k], ny[k], nc[k]);
      cyc += S * S;
      ox[k] = nx[k]; oy[k] = ny[k]; oc[k] = nc[k]; ov[k] = 1'b1;
    end
    exp_len = cyc + 1;
  endtask

  task automatic randomize_moved();
    for (int k = 0; k < N; k++) begin
      nx[k] = (ox[k] + 1 + $urandom_range(0, 200)) % 256;
      ny[k] = $urandom_range(0, 127);
      nc[k] = $urandom_range(0, 7);
    end
  endtask

  task automatic run_frame(input string name, input int hold, output int len);
    bit seen;
    apply_inputs();
    model_frame();
    got_q.delete();
    fin_cnt = 0;
    draw_squares = 1'b1;
    len = 0;
    seen = 1'b0;
    while (!seen && len < 4000) begin
      @(negedge clock);
      len++;
      if (finish_drawing_squares) seen = 1'b1;
    end
    checks++;
    if (!seen || len != exp_len) begin
      errors++;
      $display("FAIL %s frame_len: got %0d (done seen %0d) expected %0d", name, len, seen, exp_len);
    end
    repeat (hold) @(negedge clock);
    draw_squares = 1'b0;
    @(negedge clock);
    #1;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s write_count: got %0d expected %0d", name, got_q.size(), exp_q.size());
    end else begin
      for (int j = 0; j < exp_q.size(); j++) begin
        if (got_q[j] !== exp_q[j]) begin
          errors++;
          $display("FAIL %s pixel[%0d]: got x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d", name, j,
                   got_q[j][17:10], got_q[j][9:3], got_q[j][2:0],
                   exp_q[j][17:10], exp_q[j][9:3], exp_q[j][2:0]);
          break;
        end
      end
    end
    checks++;
    if (fin_cnt != 1) begin
      errors++;
      $display("FAIL %s finish_pulses: got %0d expected 1", name, fin_cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    draw_squares = 1'b0;
    sq_x = '0; sq_y = '0; sq_colour = '0;
    for (int k = 0; k < N; k++) begin ox[k] = 0; oy[k] = 0; oc[k] = 0; ov[k] = 1'b0; end
    repeat (3) @(negedge clock);
    checks++;
    if ({x_out, y_out, colour_out, writeEn, finish_drawing_squares} !== 20'd0) begin
      errors++;
      $display("FAIL reset_outputs: got x=%0d y=%0d c=%0d we=%0b fin=%0b expected all 0",
               x_out, y_out, colour_out, writeEn, finish_drawing_squares);
    end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_first_frame();
    int len;
    nx = '{10, 0, 20, 40};
    ny = '{20, 0, 0, 0};
    nc = '{4, 1, 2, 3};
    run_frame("first_frame", 0, len);
    checks++;
    if (len != 69) begin
      errors++;
      $display("FAIL first_frame_len_const: got %0d expected 69", len);
    end
    checks++;
    if (got_q.size() == 0 || got_q[0] !== {8'd10, 7'd20, 3'd4}) begin
      errors++;
      $display("FAIL first_pixel: got %h expected %h", (got_q.size() > 0) ? got_q[0] : 18'h0,
               {8'd10, 7'd20, 3'd4});
    end
  endtask

  task automatic test_move();
    int len;
    ny[0] = 21;
    run_frame("move", 0, len);
    checks++;
    if (len != (SKIP ? 37 : 133)) begin
      errors++;
      $display("FAIL move_len_const: got %0d expected %0d", len, SKIP ? 37 : 133);
    end
  endtask

  task automatic test_clip();
    int len, corner;
    nx[0] = 158;
    ny[0] = 118;
    run_frame("clip", 0, len);
    corner = 0;
    foreach (got_q[j])
      if (got_q[j][17:10] >= 8'd158 && got_q[j][9:3] >= 7'd118) corner++;
    checks++;
    if (corner != 4) begin
      errors++;
      $display("FAIL clip_corner_writes: got %0d expected 4", corner);
    end
  endtask

  task automatic test_hold();
    int len;
    randomize_moved();
    run_frame("hold_high", 300, len);
    randomize_moved();
    run_frame("rearm", 0, len);
  endtask

  task automatic test_random_frames();
    int len;
    for (int f = 0; f < 4; f++) begin
      if (f != 2) randomize_moved();
      run_frame($sformatf("random%0d", f), $urandom_range(0, 3), len);
    end
  endtask

  task automatic test_static();
    int len;
    run_frame("static", 0, len);
    checks++;
    if (len != (SKIP ? 5 : 133)) begin
      errors++;
      $display("FAIL static_len_const: got %0d expected %0d", len, SKIP ? 5 : 133);
    end
  endtask

  task automatic test_abort_draw();
    int sx[N], sy[N], sc[N];
    bit sv[N];
    int n, len;
    randomize_moved();
    apply_inputs();
    sx = ox; sy = oy; sc = oc; sv = ov;
    model_frame();
    for (int k = 2; k < N; k++) begin ox[k] = sx[k]; oy[k] = sy[k]; oc[k] = sc[k]; ov[k] = sv[k]; end
    fin_cnt = 0;
    draw_squares = 1'b1;
    n = 0;
    while (n < draw2_start + 5) begin
      @(negedge clock);
      n++;
    end
    draw_squares = 1'b0;
    @(negedge clock);
    #1;
    checks++;
    if (writeEn !== 1'b0) begin
      errors++;
      $display("FAIL abort_writeEn: got %0b expected 0", writeEn);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (fin_cnt != 0) begin
      errors++;
      $display("FAIL abort_finish: got %0d pulses expected 0", fin_cnt);
    end
    randomize_moved();
    run_frame("after_abort", 0, len);
  endtask

  task automatic test_reset_mid();
    int len;
    randomize_moved();
    apply_inputs();
    fin_cnt = 0;
    draw_squares = 1'b1;
    repeat (20) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    #1;
    checks++;
    if (writeEn !== 1'b0 || finish_drawing_squares !== 1'b0 || x_out !== 8'd0 || y_out !== 7'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got we=%0b fin=%0b x=%0d y=%0d expected 0 0 0 0",
               writeEn, finish_drawing_squares, x_out, y_out);
    end
    checks++;
    if (fin_cnt != 0) begin
      errors++;
      $display("FAIL reset_mid_finish: got %0d pulses expected 0", fin_cnt);
    end
    reset = 1'b1;
    draw_squares = 1'b0;
    for (int k = 0; k < N; k++) begin ox[k] = 0; oy[k] = 0; oc[k] = 0; ov[k] = 1'b0; end
    @(negedge clock);
    run_frame("post_reset", 0, len);
    checks++;
    if (len != 69) begin
      errors++;
      $display("FAIL post_reset_len_const: got %0d expected 69", len);
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_move();
    test_clip();
    test_hold();
    test_random_frames();
    test_static();
    test_abort_draw();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/square_renderer.md
Name: square_renderer

Overview:
- Pixel-generation datapath for the falling squares. It consumes the control FSM's draw_squares enable and returns finish_drawing_squares.
- For each square, in index order, it erases the square's previously drawn footprint in the background colour, then draws the square at its new position.
- It drives pixel coordinates, colour and write-enable to the VGA adapter on the 160x120 / 3-bit-colour frame.

Parameters:
- N_SQUARES, 4, number of squares rendered per frame (1..8).
- SIZE, 4, square edge in pixels (power of two, 2..8).
- BG_COLOUR, 3'b000, colour used for erase pixels.
- SCREEN_W, 160, pixels with x >= SCREEN_W are clipped.
- SCREEN_H, 120, pixels with y >= SCREEN_H are clipped.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-low.
- draw_squares  input  1  level enable from control FSM; high while in its square-drawing state.
- sq_x  input  N_SQUARES*8  flat bus; square i top-left x at [8i+7:8i].
- sq_y  input  N_SQUARES*7  flat bus; square i top-left y at [7i+6:7i].
- sq_colour  input  N_SQUARES*3  flat bus; square i colour at [3i+2:3i].
- x_out  output  8  pixel x to VGA adapter.
- y_out  output  7  pixel y to VGA adapter.
- colour_out  output  3  pixel colour.
- writeEn  output  1  pixel write strobe.
- finish_drawing_squares  output  1  one-cycle done pulse to control FSM.

Behaviour:
- Reset (clock edge with reset==0):
  - State goes to IDLE; all counters are 0.
  - Per-square old_valid flags are cleared; stored old_x/old_y are 0.
  - Outputs: x_out=0, y_out=0, colour_out=0, writeEn=0, finish_drawing_squares=0.
  - Reset mid-frame aborts immediately.
- Output decoding: outputs are decoded from registered state, square index i and pixel counter p. There is no extra pipeline stage, so a pixel is presented in the same cycle its counter value is held.
- States:
  - IDLE: waits for draw_squares==1 and armed==1, then goes to LOAD with i=0.
  - LOAD (1 cycle): captures new_x/new_y/new_colour for square i from the input buses. Goes to ERASE if old_valid[i], else to DRAW; p=0.
  - ERASE (SIZE*SIZE cycles): pixel p at (old_x+p%SIZE, old_y+p/SIZE), colour BG_COLOUR. After the last pixel, goes to DRAW with p=0.
  - DRAW (SIZE*SIZE cycles): pixel p at (new_x+p%SIZE, new_y+p/SIZE), colour new_colour. On the final pixel, old_x/old_y <= new_x/new_y and old_valid[i] <= 1.
  - NEXT (0 cycles, folded into the DRAW exit): if i < N_SQUARES-1, goes to LOAD with i+1; else goes to DONE.
  - DONE (1 cycle): finish_drawing_squares=1, writeEn=0, armed <= 0, then goes to IDLE.
- writeEn:
  - 1 in ERASE and DRAW unless the pixel is clipped.
  - 0 in IDLE, LOAD and DONE.
- Clipping:
  - Pixel x/y are computed one bit wider than the port width.
  - If x >= SCREEN_W or y >= SCREEN_H, writeEn=0 but the cycle is still consumed.
  - Ports carry the truncated low bits.
- Re-arm: armed is set whenever draw_squares==0, so a new frame starts only after draw_squares has been seen low at least one cycle. If control holds draw_squares high past DONE, no second pass occurs.
- Latency:
  - First LOAD is the cycle after draw_squares is sampled high in IDLE.
  - Frame length = N_SQUARES + (erase count + N_SQUARES)*SIZE^2 + 1 cycles, where erase count is the number of squares with old_valid set.
  - Steady state with defaults: 4 + 8*16 + 1 = 133 cycles.
- Abort:
  - If draw_squares drops outside IDLE/DONE, the block returns to IDLE next cycle with writeEn=0 and no finish pulse.
  - Squares that completed DRAW keep their updated old_* values.
- Inputs may change during a frame; only values captured in LOAD are used.

Optional Feature:
- Macro: SQ_SKIP_STATIC_EN.
- Defined: in LOAD, if old_valid[i] and new position equals old position and new_colour equals the stored old colour (stored only in this build), skip ERASE and DRAW. The block goes directly to NEXT, costing 1 cycle for that square.
- Not defined: every square is always erased (if valid) and redrawn; no colour storage.

Test Plan:
1. First frame after reset, defaults, square0 at (10,20) colour 3'b100, others (0,0), (20,0), (40,0) -> no ERASE; 4*(1+16)+1=69 cycles. Square0 writes (10..13, 20..23) with colour 4; exactly one finish pulse.
2. Second frame, square0 moved to (10,21) -> square0 erases (10..13, 20..23) in colour 0 before drawing (10..13, 21..24). Frame is 133 cycles.
3. Square at (158,118) -> writeEn=1 only for x in {158,159}, y in {118,119} (4 pixels); the 12 clipped cycles still elapse.
4. Hold draw_squares high for 300 cycles -> exactly one finish pulse and no writes after DONE. Drop draw_squares for 1 cycle, raise again -> a new frame starts.
5. Drop draw_squares mid-DRAW of square 2, or pull reset low -> writeEn=0 and IDLE on the next cycle, no finish pulse. After reset, the next frame has no ERASE.
6. With SQ_SKIP_STATIC_EN defined, redraw an identical frame -> 4*1+1=5 cycles, zero writes. Without the macro -> 133 cycles.
